// File: rtl/floppy_track_loader.sv
// -----------------------------------------------------------------------------
// floppy_track_loader
//   Track buffer for one 5.25" drive. Holds one nibblized track of
//   BLOCKS x 512 bytes in an internal dual-port RAM. The IWM side reads and
//   writes it at random. Whenever the requested track or disk changes, the
//   buffer is refilled from the SD block interface. A modified track on the
//   same disk is written back before it is left.
//
// Ports
//   clk, reset             system clock, synchronous active-high reset
//   ram_addr/di/we, ram_do controller port (ram_do: 1-cycle read latency)
//   track                  requested track number
//   change, mount          disk insertion toggle, disk image present
//   busy, ready, active    buffer not usable / track loaded / SD transfer running
//   sd_lba, sd_rd, sd_wr   block request to the host
//   sd_ack                 host acknowledge, high for the whole block transfer
//   sd_buff_addr/dout/wr   SD byte stream into the buffer
//   sd_buff_din            buffer byte out to SD (1-cycle latency)
// -----------------------------------------------------------------------------
module floppy_track_loader #(
    parameter int unsigned BLOCKS = 13
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [12:0] ram_addr,
    input  logic [7:0]  ram_di,
    output logic [7:0]  ram_do,
    input  logic        ram_we,

    input  logic [5:0]  track,
    output logic        busy,
    input  logic        change,
    input  logic        mount,
    output logic        ready,
    output logic        active,

    input  logic [8:0]  sd_buff_addr,
    input  logic [7:0]  sd_buff_dout,
    output logic [7:0]  sd_buff_din,
    input  logic        sd_buff_wr,

    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack
);

    localparam int unsigned BLK_BYTES = 512;
    localparam int unsigned BUF_BYTES = BLOCKS * BLK_BYTES;
    localparam int unsigned ADDR_W    = 13;
    localparam int unsigned BLK_W     = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam int unsigned TRK_W     = 6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_REQ,
        S_WB_XFER,
        S_RD_REQ,
        S_RD_XFER
    } state_t;

    state_t             state_q;
    logic [BLK_W-1:0]   blk_q;
    logic [TRK_W-1:0]   cur_track_q;
    logic [TRK_W-1:0]   track_lat_q;
    logic               valid_q;
    logic               dirty_q;
    logic               change_seen_q;
    logic               old_ack_q;
    logic               sd_rd_q;
    logic               sd_wr_q;
    logic [7:0]         ram_do_q;
    logic [7:0]         sd_buff_din_q;

    logic [7:0]         mem [0:BUF_BYTES-1];

    logic               need_c;
    logic               ack_rise_c;
    logic               ack_fall_c;
    logic               last_blk_c;
    logic               wb_phase_c;
    logic               a_we_c;
    logic               b_we_c;
    logic [ADDR_W-1:0]  b_addr_c;
    logic [TRK_W-1:0]   lba_track_c;

    // Buffer is stale when a disk is present and the loaded track/disk differs.
    assign need_c = mount & (~valid_q | (track != cur_track_q) | (change != change_seen_q));

    assign ack_rise_c = sd_ack & ~old_ack_q;
    assign ack_fall_c = ~sd_ack & old_ack_q;
    assign last_blk_c = (blk_q == BLK_W'(BLOCKS - 1));
    assign wb_phase_c = (state_q == S_WB_REQ) || (state_q == S_WB_XFER);

    // Controller writes only land on a settled buffer; out-of-range bytes are dropped.
    assign a_we_c   = ram_we & (state_q == S_IDLE) & ~need_c & (ram_addr < ADDR_W'(BUF_BYTES));
    assign b_we_c   = sd_buff_wr & sd_ack & (state_q == S_RD_XFER);
    assign b_addr_c = ADDR_W'({blk_q, sd_buff_addr});

    // Write-back targets the track being left, loads target the latched request.
    assign lba_track_c = wb_phase_c ? cur_track_q : track_lat_q;

    assign sd_lba      = 32'(lba_track_c) * 32'(BLOCKS) + 32'(blk_q);
    assign sd_rd       = sd_rd_q;
    assign sd_wr       = sd_wr_q;
    assign busy        = (state_q != S_IDLE) | need_c;
    assign ready       = mount & valid_q;
    assign active      = (state_q != S_IDLE);
    assign ram_do      = ram_do_q;
    assign sd_buff_din = sd_buff_din_q;

    // Track RAM: two read ports, one shared write port (A and B never write together).
    always_ff @(posedge clk) begin
        if (a_we_c) begin
            mem[ram_addr] <= ram_di;
        end else if (b_we_c) begin
            mem[b_addr_c] <= sd_buff_dout;
        end
        ram_do_q      <= mem[ram_addr];
        sd_buff_din_q <= mem[b_addr_c];
    end

    // Transfer sequencer: optional write-back of BLOCKS blocks, then load of BLOCKS blocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            blk_q         <= '0;
            cur_track_q   <= '0;
            track_lat_q   <= '0;
            valid_q       <= 1'b0;
            dirty_q       <= 1'b0;
            change_seen_q <= change;
            old_ack_q     <= 1'b0;
            sd_rd_q       <= 1'b0;
            sd_wr_q       <= 1'b0;
        end else begin
            old_ack_q <= sd_ack;
            case (state_q)
                S_IDLE: begin
                    if (a_we_c) begin
                        dirty_q <= 1'b1;
                    end
                    if (need_c) begin
                        blk_q <= '0;
                        if (valid_q && dirty_q && (change == change_seen_q)) begin
                            sd_wr_q <= 1'b1;
                            state_q <= S_WB_REQ;
                        end else begin
                            // New disk or nothing to save: any dirty data is discarded.
                            track_lat_q   <= track;
                            change_seen_q <= change;
                            valid_q       <= 1'b0;
                            dirty_q       <= 1'b0;
                            sd_rd_q       <= 1'b1;
                            state_q       <= S_RD_REQ;
                        end
                    end
                end

                S_WB_REQ: begin
                    if (ack_rise_c) begin
                        sd_wr_q <= 1'b0;
                        state_q <= S_WB_XFER;
                    end
                end

                S_WB_XFER: begin
                    if (ack_fall_c) begin
                        if (!last_blk_c) begin
                            blk_q   <= blk_q + BLK_W'(1);
                            sd_wr_q <= 1'b1;
                            state_q <= S_WB_REQ;
                        end else begin
                            blk_q         <= '0;
                            dirty_q       <= 1'b0;
                            track_lat_q   <= track;
                            change_seen_q <= change;
                            valid_q       <= 1'b0;
                            sd_rd_q       <= 1'b1;
                            state_q       <= S_RD_REQ;
                        end
                    end
                end

                S_RD_REQ: begin
                    if (ack_rise_c) begin
                        sd_rd_q <= 1'b0;
                        state_q <= S_RD_XFER;
                    end
                end

                S_RD_XFER: begin
                    if (ack_fall_c) begin
                        if (!last_blk_c) begin
                            blk_q   <= blk_q + BLK_W'(1);
                            sd_rd_q <= 1'b1;
                            state_q <= S_RD_REQ;
                        end else begin
                            // Load finished for the latched track; a newer request re-triggers need.
                            cur_track_q <= track_lat_q;
                            valid_q     <= 1'b1;
                            dirty_q     <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end
                end

                default: begin
                    sd_rd_q <= 1'b0;
                    sd_wr_q <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_floppy_track_loader.sv
// -----------------------------------------------------------------------------
// tb_floppy_track_loader
//   Drives the track loader through loads, write-backs, disk changes, dropped
//   writes and a mid-transfer reset. A disk image (associative array keyed by
//   absolute byte offset) and a track-buffer array model the expected data;
//   block addresses and write-back decisions follow from track arithmetic.
// -----------------------------------------------------------------------------
module tb_floppy_track_loader;

    localparam int BLOCKS  = 13;
    localparam int BUF_LEN = BLOCKS * 512;

    logic        clk = 1'b0;
    logic        reset;
    logic [12:0] ram_addr;
    logic [7:0]  ram_di;
    logic [7:0]  ram_do;
    logic        ram_we;
    logic [5:0]  track;
    logic        busy;
    logic        change;
    logic        mount;
    logic        ready;
    logic        active;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout;
    logic [7:0]  sd_buff_din;
    logic        sd_buff_wr;
    logic [31:0] sd_lba;
    logic        sd_rd;
    logic        sd_wr;
    logic        sd_ack;

    int total = 0;
    int bad   = 0;

    logic [7:0] disk_img [int];
    logic [7:0] tb_buf [0:BUF_LEN-1];
    bit         m_valid = 1'b0;
    bit         m_dirty = 1'b0;
    int         m_track = 0;

    always #5 clk = ~clk;

    floppy_track_loader #(.BLOCKS(BLOCKS)) dut (
        .clk          (clk),
        .reset        (reset),
        .ram_addr     (ram_addr),
        .ram_di       (ram_di),
        .ram_do       (ram_do),
        .ram_we       (ram_we),
        .track        (track),
        .busy         (busy),
        .change       (change),
        .mount        (mount),
        .ready        (ready),
        .active       (active),
        .sd_buff_addr (sd_buff_addr),
        .sd_buff_dout (sd_buff_dout),
        .sd_buff_din  (sd_buff_din),
        .sd_buff_wr   (sd_buff_wr),
        .sd_lba       (sd_lba),
        .sd_rd        (sd_rd),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack)
    );

    // Host side of one block transfer: wait for a request, check it, move 512 bytes.
    task automatic serve_block(input bit is_wr, input int exp_lba, input int buf_blk);
        int         n;
        int         nbad;
        int         fi;
        logic [7:0] got;
        logic [7:0] fa;
        logic [7:0] fe;
        n = 0;
        while (!(sd_rd || sd_wr) && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (!(sd_rd || sd_wr)) begin
            bad++;
            $display("FAIL req_timeout: no request within 100 cycles, expected %s lba=%0d",
                     is_wr ? "write" : "read", exp_lba);
            return;
        end
        total++;
        if (sd_wr !== is_wr || sd_rd !== !is_wr) begin
            bad++;
            $display("FAIL req_kind lba=%0d: got sd_rd=%b sd_wr=%b, expected sd_wr=%b",
                     exp_lba, sd_rd, sd_wr, is_wr);
        end
        total++;
        if (sd_lba !== 32'(exp_lba)) begin
            bad++;
            $display("FAIL req_lba: got %0d expected %0d", sd_lba, exp_lba);
        end
        sd_ack = 1'b1;
        @(negedge clk);
        total++;
        if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
            bad++;
            $display("FAIL req_drop lba=%0d: got sd_rd=%b sd_wr=%b expected 0/0",
                     exp_lba, sd_rd, sd_wr);
        end
        if (!is_wr) begin
            for (int i = 0; i < 512; i++) begin
                if (!disk_img.exists(exp_lba * 512 + i))
                    disk_img[exp_lba * 512 + i] = 8'($urandom);
                sd_buff_addr = 9'(i);
                sd_buff_dout = disk_img[exp_lba * 512 + i];
                sd_buff_wr   = 1'b1;
                @(negedge clk);
                tb_buf[buf_blk * 512 + i] = disk_img[exp_lba * 512 + i];
            end
            sd_buff_wr = 1'b0;
        end else begin
            nbad = 0;
            fi   = 0;
            fa   = 8'h00;
            fe   = 8'h00;
            sd_buff_addr = 9'd0;
            @(negedge clk);
            for (int i = 0; i < 512; i++) begin
                got = sd_buff_din;
                if (got !== tb_buf[buf_blk * 512 + i]) begin
                    if (nbad == 0) begin
                        fi = i;
                        fa = got;
                        fe = tb_buf[buf_blk * 512 + i];
                    end
                    nbad++;
                end
                disk_img[exp_lba * 512 + i] = tb_buf[buf_blk * 512 + i];
                sd_buff_addr = 9'(i + 1);
                @(negedge clk);
            end
            total++;
            if (nbad != 0) begin
                bad++;
                $display("FAIL wb_data lba=%0d byte=%0d: got %02h expected %02h (%0d bytes differ)",
                         exp_lba, fi, fa, fe, nbad);
            end
        end
        sd_ack = 1'b0;
        ram_we = 1'b0;
        @(negedge clk);
    endtask

    // Full track switch as the model predicts it: write-back only for a dirty track on the same disk.
    task automatic do_load(input int new_track, input bit new_disk);
        bit exp_wb;
        int old_track;
        exp_wb    = m_valid && m_dirty && !new_disk;
        old_track = m_track;
        if (exp_wb)
            for (int b = 0; b < BLOCKS; b++) serve_block(1'b1, old_track * BLOCKS + b, b);
        for (int b = 0; b < BLOCKS; b++) serve_block(1'b0, new_track * BLOCKS + b, b);
        m_valid = 1'b1;
        m_dirty = 1'b0;
        m_track = new_track;
        total++;
        if (busy !== 1'b0 || ready !== 1'b1 || active !== 1'b0) begin
            bad++;
            $display("FAIL load_done trk=%0d: got busy=%b ready=%b active=%b expected 0/1/0",
                     new_track, busy, ready, active);
        end
        repeat (2) @(negedge clk);
        total++;
        if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
            bad++;
            $display("FAIL idle_quiet trk=%0d: got sd_rd=%b sd_wr=%b expected 0/0",
                     new_track, sd_rd, sd_wr);
        end
    endtask

    task automatic check_ram(input int addr);
        ram_addr = 13'(addr);
        @(negedge clk);
        total++;
        if (ram_do !== tb_buf[addr]) begin
            bad++;
            $display("FAIL ram_read addr=%0d: got %02h expected %02h", addr, ram_do, tb_buf[addr]);
        end
    endtask

    task automatic ctrl_write(input int addr, input logic [7:0] data);
        ram_addr = 13'(addr);
        ram_di   = data;
        ram_we   = 1'b1;
        @(negedge clk);
        ram_we   = 1'b0;
        tb_buf[addr] = data;
        m_dirty = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; mount = 1'b0; change = 1'b0; track = 6'd0;
        ram_we = 1'b0; ram_addr = '0; ram_di = '0;
        sd_ack = 1'b0; sd_buff_wr = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
            bad++;
            $display("FAIL reset_req: got sd_rd=%b sd_wr=%b expected 0/0", sd_rd, sd_wr);
        end
        total++;
        if (sd_lba !== 32'd0) begin
            bad++;
            $display("FAIL reset_lba: got %0d expected 0", sd_lba);
        end
        total++;
        if (active !== 1'b0 || ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: got active=%b ready=%b busy=%b expected 0/0/0",
                     active, ready, busy);
        end
        repeat (5) @(negedge clk);
        total++;
        if (sd_rd !== 1'b0 || active !== 1'b0) begin
            bad++;
            $display("FAIL unmounted_idle: got sd_rd=%b active=%b expected 0/0", sd_rd, active);
        end
    endtask

    task automatic test_first_load;
        for (int i = 0; i < BUF_LEN; i++) disk_img[i] = 8'hA5;
        mount  = 1'b1;
        change = ~change;
        track  = 6'd0;
        do_load(0, 1'b0);
        ram_addr = 13'd0;
        @(negedge clk);
        total++;
        if (ram_do !== 8'hA5) begin
            bad++;
            $display("FAIL first_byte: got %02h expected a5", ram_do);
        end
        mount = 1'b0;
        @(negedge clk);
        total++;
        if (ready !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL unmount: got ready=%b busy=%b expected 0/0", ready, busy);
        end
        mount = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (ready !== 1'b1 || busy !== 1'b0 || sd_rd !== 1'b0) begin
            bad++;
            $display("FAIL remount: got ready=%b busy=%b sd_rd=%b expected 1/0/0", ready, busy, sd_rd);
        end
    endtask

    task automatic test_track_step;
        track = 6'd3;
        do_load(3, 1'b0);
        for (int k = 0; k < 4; k++) check_ram($urandom_range(0, BUF_LEN - 1));
    endtask

    task automatic test_writeback;
        for (int k = 0; k < 4; k++) ctrl_write($urandom_range(0, BUF_LEN - 1), 8'($urandom));
        ctrl_write(100, 8'h5A);
        check_ram(100);
        track = 6'd4;
        do_load(4, 1'b0);
        for (int k = 0; k < 3; k++) check_ram($urandom_range(0, BUF_LEN - 1));
    endtask

    task automatic test_disk_change;
        ctrl_write($urandom_range(0, BUF_LEN - 1), 8'($urandom));
        disk_img.delete();
        change = ~change;
        do_load(4, 1'b1);
        check_ram($urandom_range(0, BUF_LEN - 1));
    endtask

    task automatic test_busy_write;
        int trk;
        trk = $urandom_range(5, 40);
        track    = 6'(trk);
        ram_addr = 13'd0;
        ram_di   = 8'h33;
        ram_we   = 1'b1;
        do_load(trk, 1'b0);
        check_ram(0);
        track = 6'(trk + 1);
        do_load(trk + 1, 1'b0);
    endtask

    task automatic test_reset_mid;
        int trk;
        int n;
        trk   = $urandom_range(43, 62);
        track = 6'(trk);
        n = 0;
        while (!sd_rd && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (sd_rd !== 1'b1) begin
            bad++;
            $display("FAIL mid_req: got sd_rd=%b expected 1", sd_rd);
        end
        sd_ack = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            sd_buff_addr = 9'(i);
            sd_buff_dout = 8'($urandom);
            sd_buff_wr   = 1'b1;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (sd_rd !== 1'b0 || sd_wr !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_req: got sd_rd=%b sd_wr=%b expected 0/0", sd_rd, sd_wr);
        end
        total++;
        if (active !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_status: got active=%b ready=%b expected 0/0", active, ready);
        end
        reset      = 1'b0;
        sd_ack     = 1'b0;
        sd_buff_wr = 1'b0;
        m_valid    = 1'b0;
        m_dirty    = 1'b0;
        do_load(trk, 1'b0);
        check_ram($urandom_range(0, BUF_LEN - 1));
    endtask

    initial begin
        test_reset;
        test_first_load;
        test_track_step;
        test_writeback;
        test_disk_change;
        test_busy_write;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
